sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one spi_sram_encoder instance between two requester ports. Port 0 is the CPU data/instruction side. Port 1 is the loader/display side.
- Arbitrates between pending requests and drives the encoder's request/address/write_enable/data_out.
- Tracks the encoder's busy handshake and returns read data with a one-cycle ack to the granted port.
- Sits between the hack_soc CPU/peripheral logic and the SPI SRAM encoder.

Parameters:
- WORD_WIDTH, 16, data word width on both ports and the encoder interface.
- ADDRESS_WIDTH, 16, word address width on both ports and the encoder interface.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- p0_req  input  1  port 0 request; level, held until p0_ack.
- p0_addr  input  ADDRESS_WIDTH  port 0 word address.
- p0_we  input  1  port 0 write enable.
- p0_wdata  input  WORD_WIDTH  port 0 write data.
- p0_ack  output  1  one-cycle completion pulse.
- p0_rdata  output  WORD_WIDTH  read data (write data echoed on writes); valid while p0_ack=1.
- p1_req, p1_addr, p1_we, p1_wdata, p1_ack, p1_rdata: same as port 0, for port 1.
- enc_request  output  1  to encoder request.
- enc_address  output  ADDRESS_WIDTH  to encoder address.
- enc_write_enable  output  1  to encoder write_enable.
- enc_data_out  output  WORD_WIDTH  to encoder data_out.
- enc_busy  input  1  from encoder busy.
- enc_initialized  input  1  from encoder initialized.
- enc_data_in  input  WORD_WIDTH  from encoder data_in.
- grant  output  1  index of the port owning the current or last transaction.
- arb_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE.
  - enc_request=0; enc_address, enc_write_enable, enc_data_out = 0.
  - p0_ack = p1_ack = 0; p0_rdata = p1_rdata = 0.
  - grant=0; last_grant=1, so port 0 wins the first contention.
  - arb_busy=0.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_DONE, RESPOND.
- IDLE:
  - A grant is allowed only when enc_initialized=1, enc_busy=0 and at least one req is high.
  - Selection is round-robin: if both req are high, the port != last_grant wins; otherwise the single requester wins.
  - On grant, capture the winning port's addr/we/wdata into the enc_* registers; set grant and last_grant; enc_request<=1; go to ISSUE.
- ISSUE:
  - Hold enc_request=1 and all enc_* signals stable until enc_busy=1 is sampled.
  - On enc_busy=1: enc_request<=0; go to WAIT_DONE.
  - The encoder accepts only on its SCK phase, so ISSUE lasts 1–3 cycles.
- WAIT_DONE: on enc_busy=0, latch rdata for the granted port from enc_data_in; assert that port's ack; go to RESPOND.
- RESPOND:
  - Ack high for exactly this one cycle. rdata holds its value until the next transaction on the same port.
  - Next state is IDLE; no grant is made in the RESPOND cycle.
- A requester samples ack and drops or changes req on the following edge. A req still high in IDLE is treated as a new request.
- Port request inputs are ignored outside IDLE. Changing addr/we/wdata after grant has no effect.
- Simultaneous new req on the non-granted port during a transaction: served in the next IDLE.
- Reset mid-transaction:
  - The arbiter returns to IDLE immediately and drops enc_request; no ack is issued for the aborted transaction.
  - The encoder may still be busy; IDLE waits for enc_busy=0 before the next grant.
- enc_initialized=0 (encoder init sequence): no grants; requests stay pending.
- Minimum turnaround between consecutive acks is one IDLE cycle.

Optional Feature:
- Macro: SRAM_ARB_FIXED_PRIO_EN.
- When defined: fixed priority, port 0 always wins contention. last_grant is still updated but not used for selection.
- When undefined: round-robin as above.

Test Plan:
- Encoder held uninitialized, p0_req=1 addr=16'h0010 -> no enc_request. Raise enc_initialized -> enc_request=1 with enc_address=16'h0010 on the next cycle.
- p0 write addr=16'h0004 wdata=16'hBEEF; encoder model busy 20 cycles, then data_in=16'hBEEF -> exactly one p0_ack pulse, p0_rdata=16'hBEEF, p1_ack stays 0.
- p0 and p1 reads requested in the same cycle, both held through two transactions -> first grant=0, second grant=1, ack order p0 then p1. With SRAM_ARB_FIXED_PRIO_EN and p0_req held continuously -> p1 never granted.
- p1 read addr=16'hAED0, encoder returns 16'h1234 -> p1_rdata=16'h1234 during p1_ack; enc_request deasserted the cycle after enc_busy is first seen high.
- reset_n pulsed low while in WAIT_DONE -> outputs return to reset values asynchronously. Next grant occurs only after enc_busy=0, and no stale ack is produced.
- p0 changes p0_addr from 16'h0001 to 16'h0002 during ISSUE -> enc_address stays 16'h0001 until ack.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of one SPI SRAM encoder. Round-robin by default;
// define SRAM_ARB_FIXED_PRIO_EN for fixed priority to port 0. All outputs are registered.
module sram_port_arbiter #(
  parameter int WORD_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     p0_req,
  input  logic [ADDRESS_WIDTH-1:0] p0_addr,
  input  logic                     p0_we,
  input  logic [WORD_WIDTH-1:0]    p0_wdata,
  output logic                     p0_ack,
  output logic [WORD_WIDTH-1:0]    p0_rdata,
  input  logic                     p1_req,
  input  logic [ADDRESS_WIDTH-1:0] p1_addr,
  input  logic                     p1_we,
  input  logic [WORD_WIDTH-1:0]    p1_wdata,
  output logic                     p1_ack,
  output logic [WORD_WIDTH-1:0]    p1_rdata,
  output logic                     enc_request,
  output logic [ADDRESS_WIDTH-1:0] enc_address,
  output logic                     enc_write_enable,
  output logic [WORD_WIDTH-1:0]    enc_data_out,
  input  logic                     enc_busy,
  input  logic                     enc_initialized,
  input  logic [WORD_WIDTH-1:0]    enc_data_in,
  output logic                     grant,
  output logic                     arb_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESPOND} state_t;

  state_t                   state, state_nxt;
  logic                     last_grant, last_grant_nxt;
  logic                     winner;
  logic                     grant_nxt;
  logic                     enc_request_nxt;
  logic [ADDRESS_WIDTH-1:0] enc_address_nxt;
  logic                     enc_write_enable_nxt;
  logic [WORD_WIDTH-1:0]    enc_data_out_nxt;
  logic                     p0_ack_nxt, p1_ack_nxt;
  logic [WORD_WIDTH-1:0]    p0_rdata_nxt, p1_rdata_nxt;
  logic                     arb_busy_nxt;

  // winner is only consumed when at least one port is requesting
  always_comb begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
    winner = ~p0_req;
`else
    winner = (p0_req && p1_req) ? ~last_grant : p1_req;
`endif
  end

  always_comb begin
    state_nxt            = state;
    last_grant_nxt       = last_grant;
    grant_nxt            = grant;
    enc_request_nxt      = enc_request;
    enc_address_nxt      = enc_address;
    enc_write_enable_nxt = enc_write_enable;
    enc_data_out_nxt     = enc_data_out;
    p0_ack_nxt           = 1'b0;
    p1_ack_nxt           = 1'b0;
    p0_rdata_nxt         = p0_rdata;
    p1_rdata_nxt         = p1_rdata;
    case (state)
      IDLE: begin
        if (enc_initialized && !enc_busy && (p0_req || p1_req)) begin
          grant_nxt            = winner;
          last_grant_nxt       = winner;
          enc_request_nxt      = 1'b1;
          enc_address_nxt      = winner ? p1_addr  : p0_addr;
          enc_write_enable_nxt = winner ? p1_we    : p0_we;
          enc_data_out_nxt     = winner ? p1_wdata : p0_wdata;
          state_nxt            = ISSUE;
        end
      end
      ISSUE: begin
        if (enc_busy) begin
          enc_request_nxt = 1'b0;
          state_nxt       = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!enc_busy) begin
          if (grant) begin
            p1_ack_nxt   = 1'b1;
            p1_rdata_nxt = enc_data_in;
          end else begin
            p0_ack_nxt   = 1'b1;
            p0_rdata_nxt = enc_data_in;
          end
          state_nxt = RESPOND;
        end
      end
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    arb_busy_nxt = (state_nxt != IDLE);
  end

  // Reset abandons any transaction in flight; IDLE re-checks enc_busy before granting
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      last_grant       <= 1'b1;
      grant            <= 1'b0;
      enc_request      <= 1'b0;
      enc_address      <= '0;
      enc_write_enable <= 1'b0;
      enc_data_out     <= '0;
      p0_ack           <= 1'b0;
      p1_ack           <= 1'b0;
      p0_rdata         <= '0;
      p1_rdata         <= '0;
      arb_busy         <= 1'b0;
    end else begin
      state            <= state_nxt;
      last_grant       <= last_grant_nxt;
      grant            <= grant_nxt;
      enc_request      <= enc_request_nxt;
      enc_address      <= enc_address_nxt;
      enc_write_enable <= enc_write_enable_nxt;
      enc_data_out     <= enc_data_out_nxt;
      p0_ack           <= p0_ack_nxt;
      p1_ack           <= p1_ack_nxt;
      p0_rdata         <= p0_rdata_nxt;
      p1_rdata         <= p1_rdata_nxt;
      arb_busy         <= arb_busy_nxt;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural encoder, transaction-level reference model
// checked every cycle, and directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [15:0] p0_addr = '0, p0_wdata = '0, p1_addr = '0, p1_wdata = '0;
  logic        p0_ack, p1_ack;
  logic [15:0] p0_rdata, p1_rdata;
  logic        enc_request, enc_write_enable;
  logic [15:0] enc_address, enc_data_out;
  logic        enc_busy = 1'b0, enc_initialized = 1'b0;
  logic [15:0] enc_data_in = '0;
  logic        grant, arb_busy;

  always #5 clk = ~clk;

  sram_port_arbiter #(.WORD_WIDTH(16), .ADDRESS_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_we(p0_we), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_we(p1_we), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .enc_request(enc_request), .enc_address(enc_address),
    .enc_write_enable(enc_write_enable), .enc_data_out(enc_data_out),
    .enc_busy(enc_busy), .enc_initialized(enc_initialized), .enc_data_in(enc_data_in),
    .grant(grant), .arb_busy(arb_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // SRAM contents: unwritten words read back as address ^ 5A5A
  logic [15:0] mem [logic [15:0]];
  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 16'h5A5A;
  endfunction

  // Encoder: accepts a request after acc_delay extra cycles, stays busy busy_len cycles
  int acc_delay = 0;
  int busy_len  = 4;
  initial begin : encoder
    int acc_cnt, cnt;
    logic [15:0] cap_addr, cap_d;
    logic cap_we;
    acc_cnt = 0; cnt = 0; cap_addr = '0; cap_d = '0; cap_we = 1'b0;
    forever begin
      @(negedge clk);
      if (!enc_busy) begin
        if (enc_request) begin
          if (acc_cnt >= acc_delay) begin
            enc_busy = 1'b1; cnt = busy_len; acc_cnt = 0;
            cap_addr = enc_address; cap_we = enc_write_enable; cap_d = enc_data_out;
          end else acc_cnt++;
        end else acc_cnt = 0;
      end else if (cnt <= 1) begin
        enc_busy = 1'b0;
        if (cap_we) begin
          mem[cap_addr] = cap_d;
          enc_data_in = cap_d;
        end else enc_data_in = mem_rd(cap_addr);
      end else cnt--;
    end
  end

  // Reference model: one outstanding transaction, cool-down cycle after each ack
  logic        m_active = 0, m_accepted = 0, m_cool = 0, m_last = 1, m_port = 0, m_we = 0;
  logic [15:0] m_addr = '0, m_wd = '0;
  logic        exp_req = 0, exp_we = 0, exp_grant = 0, exp_ack0 = 0, exp_ack1 = 0;
  logic [15:0] exp_addr = '0, exp_wd = '0, exp_rd0 = '0, exp_rd1 = '0;

  initial begin : model
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_active = 0; m_accepted = 0; m_cool = 0; m_last = 1;
        exp_req = 0; exp_we = 0; exp_grant = 0; exp_ack0 = 0; exp_ack1 = 0;
        exp_addr = '0; exp_wd = '0; exp_rd0 = '0; exp_rd1 = '0;
      end else begin
        exp_ack0 = 0;
        exp_ack1 = 0;
        if (m_cool) m_cool = 0;
        else if (!m_active) begin
          if (enc_initialized && !enc_busy && (p0_req || p1_req)) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            m_port = p0_req ? 1'b0 : 1'b1;
`else
            if (p0_req && p1_req) m_port = (m_last == 1'b0);
            else m_port = p1_req;
`endif
            m_last = m_port;
            m_addr = m_port ? p1_addr : p0_addr;
            m_we   = m_port ? p1_we : p0_we;
            m_wd   = m_port ? p1_wdata : p0_wdata;
            m_active = 1; m_accepted = 0;
            exp_grant = m_port; exp_req = 1;
            exp_addr = m_addr; exp_we = m_we; exp_wd = m_wd;
          end
        end else if (!m_accepted) begin
          if (enc_busy) begin m_accepted = 1; exp_req = 0; end
        end else if (!enc_busy) begin
          if (m_port) begin exp_ack1 = 1; exp_rd1 = m_we ? m_wd : mem_rd(m_addr); end
          else        begin exp_ack0 = 1; exp_rd0 = m_we ? m_wd : mem_rd(m_addr); end
          m_active = 0; m_cool = 1;
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk1 ("cyc enc_request", enc_request, exp_req);
        chk16("cyc enc_address", enc_address, exp_addr);
        chk1 ("cyc enc_write_enable", enc_write_enable, exp_we);
        chk16("cyc enc_data_out", enc_data_out, exp_wd);
        chk1 ("cyc grant", grant, exp_grant);
        chk1 ("cyc arb_busy", arb_busy, m_active | m_cool);
        chk1 ("cyc p0_ack", p0_ack, exp_ack0);
        chk1 ("cyc p1_ack", p1_ack, exp_ack1);
        chk16("cyc p0_rdata", p0_rdata, exp_rd0);
        chk16("cyc p1_rdata", p1_rdata, exp_rd1);
      end
    end
  end

  int   n_ack0 = 0, n_ack1 = 0;
  int   grant_log[$];
  int   ack_log[$];
  logic mon_prev_req = 1'b0;
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (p0_ack) begin n_ack0++; ack_log.push_back(0); end
        if (p1_ack) begin n_ack1++; ack_log.push_back(1); end
        if (enc_request && !mon_prev_req) grant_log.push_back(grant ? 1 : 0);
        mon_prev_req = enc_request;
      end else mon_prev_req = 1'b0;
    end
  end

  task automatic wait_ack(input int port, input int max, output logic ok, output logic [15:0] rd);
    ok = 1'b0;
    rd = '0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if ((port == 0) ? p0_ack : p1_ack) begin
        ok = 1'b1;
        rd = (port == 0) ? p0_rdata : p1_rdata;
        return;
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion by 200us, expected summary");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic ok, pr;
    logic [15:0] rd;
    int c0, c1, bad;
    mem[16'hAED0] = 16'h1234;

    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk1 ("rst enc_request", enc_request, 1'b0);
    chk1 ("rst arb_busy", arb_busy, 1'b0);
    chk1 ("rst grant", grant, 1'b0);
    chk16("rst enc_address", enc_address, 16'h0000);
    chk1 ("rst p0_ack", p0_ack, 1'b0);
    chk16("rst p0_rdata", p0_rdata, 16'h0000);

    // encoder uninitialised: request stays pending
    p0_req = 1'b1; p0_addr = 16'h0010; p0_we = 1'b0;
    repeat (4) @(negedge clk);
    chk1("uninit no request", enc_request, 1'b0);
    enc_initialized = 1'b1;
    @(negedge clk);
    chk1 ("init request", enc_request, 1'b1);
    chk16("init address", enc_address, 16'h0010);
    wait_ack(0, 100, ok, rd);
    p0_req = 1'b0;
    chk1 ("t1 ack seen", ok, 1'b1);
    chk16("t1 rdata", rd, 16'h5A4A);

    // long write
    @(negedge clk);
    c0 = n_ack0; c1 = n_ack1;
    busy_len = 20;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 16'h0004; p0_wdata = 16'hBEEF;
    wait_ack(0, 100, ok, rd);
    p0_req = 1'b0; p0_we = 1'b0;
    repeat (3) @(negedge clk);
    chk1   ("t2 ack seen", ok, 1'b1);
    chk16  ("t2 rdata", rd, 16'hBEEF);
    chk_int("t2 p0 ack pulses", n_ack0 - c0, 1);
    chk_int("t2 p1 ack pulses", n_ack1 - c1, 0);

    // contention from reset state
    @(posedge clk); #2 reset_n = 1'b0;
    @(posedge clk); #2 reset_n = 1'b1;
    @(negedge clk);
    grant_log.delete(); ack_log.delete();
    acc_delay = 1; busy_len = 4;
    c1 = n_ack1;
    p0_addr = 16'h0020; p1_addr = 16'h0030; p0_we = 1'b0; p1_we = 1'b0;
    p0_req = 1'b1; p1_req = 1'b1;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    c0 = 0;
    for (int i = 0; i < 400 && c0 < 3; i++) begin
      @(negedge clk);
      if (p0_ack) c0++;
    end
    p0_req = 1'b0;
    chk_int("fp p0 acks", c0, 3);
    chk_int("fp p1 starved", n_ack1 - c1, 0);
    chk_int("fp first grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    wait_ack(1, 200, ok, rd);
    p1_req = 1'b0;
    chk1 ("fp p1 served", ok, 1'b1);
    chk16("fp p1 rdata", rd, 16'h5A6A);
`else
    wait_ack(1, 200, ok, rd);
    p0_req = 1'b0; p1_req = 1'b0;
    repeat (3) @(negedge clk);
    chk1   ("rr p1 ack seen", ok, 1'b1);
    chk16  ("rr p1 rdata", rd, 16'h5A6A);
    chk16  ("rr p0 rdata", p0_rdata, 16'h5A7A);
    chk_int("rr ack count", ack_log.size(), 2);
    chk_int("rr first ack", (ack_log.size() > 0) ? ack_log[0] : -1, 0);
    chk_int("rr second ack", (ack_log.size() > 1) ? ack_log[1] : -1, 1);
    chk_int("rr first grant", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    chk_int("rr second grant", (grant_log.size() > 1) ? grant_log[1] : -1, 1);
`endif

    // p1 read, slow acceptance
    @(negedge clk);
    acc_delay = 2; busy_len = 6;
    p1_addr = 16'hAED0; p1_we = 1'b0; p1_req = 1'b1;
    ok = 1'b0; pr = 1'b0; bad = 1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk); #1;
      if (enc_busy) begin
        ok = 1'b1;
        chk1("t4 req dropped after busy", enc_request, 1'b0);
        chk1("t4 req high before busy", pr, 1'b1);
      end
      pr = enc_request;
    end
    chk1("t4 busy seen", ok, 1'b1);
    wait_ack(1, 100, ok, rd);
    p1_req = 1'b0;
    chk1 ("t4 ack seen", ok, 1'b1);
    chk16("t4 rdata", rd, 16'h1234);

    // reset while waiting for the encoder
    @(negedge clk);
    acc_delay = 0; busy_len = 15;
    p0_addr = 16'h0040; p0_we = 1'b0; p0_req = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(posedge clk); #1;
      if (enc_busy && !enc_request && arb_busy) ok = 1'b1;
    end
    chk1("t5 reached wait", ok, 1'b1);
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk1 ("t5 async enc_request", enc_request, 1'b0);
    chk1 ("t5 async arb_busy", arb_busy, 1'b0);
    chk1 ("t5 async grant", grant, 1'b0);
    chk16("t5 async p1_rdata", p1_rdata, 16'h0000);
    chk16("t5 async enc_address", enc_address, 16'h0000);
    @(posedge clk); #2 reset_n = 1'b1;
    #1 chk1("t5 encoder still busy", enc_busy, 1'b1);
    c0 = n_ack0; ok = 1'b0; pr = 1'b1;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk); #1;
      if (enc_request) begin ok = 1'b1; pr = enc_busy; end
    end
    chk1   ("t5 regrant", ok, 1'b1);
    chk1   ("t5 busy low at regrant", pr, 1'b0);
    chk_int("t5 no stale ack", n_ack0 - c0, 0);
    wait_ack(0, 100, ok, rd);
    p0_req = 1'b0;
    chk1 ("t5 ack seen", ok, 1'b1);
    chk16("t5 rdata", rd, 16'h5A1A);

    // request fields change after grant
    @(negedge clk);
    acc_delay = 2; busy_len = 5;
    p0_addr = 16'h0001; p0_we = 1'b0; p0_req = 1'b1;
    @(negedge clk);
    chk1("t6 issued", enc_request, 1'b1);
    p0_addr = 16'h0002; p0_we = 1'b1; p0_wdata = 16'hFFFF;
    bad = 0; ok = 1'b0; rd = '0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (enc_address !== 16'h0001 || enc_write_enable !== 1'b0) bad++;
      if (p0_ack) begin ok = 1'b1; rd = p0_rdata; end
    end
    p0_req = 1'b0; p0_we = 1'b0;
    chk1   ("t6 ack seen", ok, 1'b1);
    chk_int("t6 address held", bad, 0);
    chk16  ("t6 rdata", rd, 16'h5A5B);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
